// File: rtl/mem_access_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_multi : multicycle-core load/store unit with a req/ack memory   |
// |                    port, lane steering, extension and error reporting.    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_access_multi #(
    parameter int          TIMEOUT        = 255,
    parameter logic [31:0] RESET_VEC_DATA = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    input  logic [2:0]  iFunct3,
    output logic [31:0] oRData,
    output logic        oReady,
    output logic        oBusy,
    output logic [1:0]  oErr,
    output logic        oMReq,
    output logic        oMWrite,
    output logic [29:0] oMAddr,
    output logic [31:0] oMWData,
    output logic [3:0]  oMByteEn,
    input  logic        iMAck,
    input  logic [31:0] iMRData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int             CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    state_t           state_q,   state_d;
    logic             lvl_q,     lvl_d;
    logic             armed_q,   armed_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [2:0]       funct3_q,  funct3_d;
    logic             mwrite_q,  mwrite_d;
    logic [29:0]      maddr_q,   maddr_d;
    logic [31:0]      mwdata_q,  mwdata_d;
    logic [3:0]       byteen_q,  byteen_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       err_q,     err_d;
    logic [31:0]      rdata_q,   rdata_d;

    logic        req_lvl;
    logic        bad_f3;
    logic        misaligned;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    always_comb begin
        req_lvl    = iMemRead | iMemWrite;
        bad_f3     = (iFunct3 == 3'b011) || (iFunct3 == 3'b110) || (iFunct3 == 3'b111);
        misaligned = ((iFunct3[1:0] == 2'b01) && iAddr[0]) ||
                     ((iFunct3[1:0] == 2'b10) && (iAddr[1:0] != 2'b00));

        shifted = iMRData >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase

        state_d   = state_q;
        lvl_d     = req_lvl;
        // A level seen high straight out of reset must drop once before it can trigger.
        armed_d   = armed_q | ~req_lvl;
        addr_lo_d = addr_lo_q;
        funct3_d  = funct3_q;
        mwrite_d  = mwrite_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        byteen_d  = byteen_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_lvl && !lvl_q && armed_q) begin
                    addr_lo_d = iAddr[1:0];
                    funct3_d  = iFunct3;
                    mwrite_d  = iMemWrite;
                    maddr_d   = iAddr[31:2];
                    cnt_d     = '0;
                    err_d     = ERR_NONE;
                    case (iFunct3[1:0])
                        2'b00: begin
                            mwdata_d = {4{iWData[7:0]}};
                            byteen_d = 4'b0001 << iAddr[1:0];
                        end
                        2'b01: begin
                            mwdata_d = {2{iWData[15:0]}};
                            byteen_d = 4'b0011 << iAddr[1:0];
                        end
                        default: begin
                            mwdata_d = iWData;
                            byteen_d = 4'b1111;
                        end
                    endcase
                    if (!iMemWrite) begin
                        byteen_d = 4'b1111;
                    end
                    if ((iMemRead && iMemWrite) || bad_f3) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = S_DONE;
                    end else if (misaligned) begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // An acknowledge on the final allowed cycle still completes normally.
                if (iMAck) begin
                    if (!mwrite_q) begin
                        rdata_d = load_ext;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q   <= S_IDLE;
            lvl_q     <= 1'b0;
            armed_q   <= 1'b0;
            addr_lo_q <= 2'b00;
            funct3_q  <= 3'b000;
            mwrite_q  <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            byteen_q  <= 4'b0000;
            cnt_q     <= '0;
            err_q     <= ERR_NONE;
            rdata_q   <= RESET_VEC_DATA;
        end else begin
            state_q   <= state_d;
            lvl_q     <= lvl_d;
            armed_q   <= armed_d;
            addr_lo_q <= addr_lo_d;
            funct3_q  <= funct3_d;
            mwrite_q  <= mwrite_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            byteen_q  <= byteen_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign oMReq    = (state_q == S_REQ);
    assign oReady   = (state_q == S_DONE);
    assign oBusy    = (state_q != S_IDLE);
    assign oMWrite  = mwrite_q;
    assign oMAddr   = maddr_q;
    assign oMWData  = mwdata_q;
    assign oMByteEn = byteen_q;
    assign oErr     = err_q;
    assign oRData   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_multi : directed self-checking bench for mem_access_multi.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_access_multi;

    localparam logic [31:0] RST_DATA = 32'hDEAD_BEEF;

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic        iMemRead, iMemWrite;
    logic [31:0] iAddr, iWData;
    logic [2:0]  iFunct3;
    logic [31:0] oRData;
    logic        oReady, oBusy;
    logic [1:0]  oErr;
    logic        oMReq, oMWrite;
    logic [29:0] oMAddr;
    logic [31:0] oMWData;
    logic [3:0]  oMByteEn;
    logic        iMAck;
    logic [31:0] iMRData;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_rdata;

    mem_access_multi #(
        .TIMEOUT        (4),
        .RESET_VEC_DATA (RST_DATA)
    ) dut (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iMemRead  (iMemRead),
        .iMemWrite (iMemWrite),
        .iAddr     (iAddr),
        .iWData    (iWData),
        .iFunct3   (iFunct3),
        .oRData    (oRData),
        .oReady    (oReady),
        .oBusy     (oBusy),
        .oErr      (oErr),
        .oMReq     (oMReq),
        .oMWrite   (oMWrite),
        .oMAddr    (oMAddr),
        .oMWData   (oMWData),
        .oMByteEn  (oMByteEn),
        .iMAck     (iMAck),
        .iMRData   (iMRData)
    );

    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Raise a request level; on return the accepting edge has just passed.
    task automatic start_req(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] f3);
        iMemRead  = rd;
        iMemWrite = wr;
        iAddr     = a;
        iWData    = wd;
        iFunct3   = f3;
        step();
    endtask

    task automatic test_reset();
        iRST_n = 1'b0;
        step();
        step();
        total++; if (oRData !== RST_DATA) begin bad++; $display("FAIL rst_rdata got=%h exp=%h", oRData, RST_DATA); end
        total++; if (oMReq !== 1'b0) begin bad++; $display("FAIL rst_mreq got=%b exp=0", oMReq); end
        total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", oBusy); end
        total++; if (oReady !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", oReady); end
        total++; if (oErr !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", oErr); end
        total++; if (oMByteEn !== 4'b0000) begin bad++; $display("FAIL rst_byteen got=%b exp=0000", oMByteEn); end
        total++; if (oMAddr !== 30'h0) begin bad++; $display("FAIL rst_maddr got=%h exp=0", oMAddr); end
        total++; if (oMWData !== 32'h0) begin bad++; $display("FAIL rst_mwdata got=%h exp=0", oMWData); end
        total++; if (oMWrite !== 1'b0) begin bad++; $display("FAIL rst_mwrite got=%b exp=0", oMWrite); end
        iRST_n = 1'b1;
        step();
        exp_rdata = RST_DATA;
    endtask

    task automatic test_lw();
        start_req(1'b1, 1'b0, 32'h0000_0104, 32'h0, 3'b010);
        total++; if (oMReq !== 1'b1) begin bad++; $display("FAIL lw_mreq got=%b exp=1", oMReq); end
        total++; if (oMAddr !== 30'h41) begin bad++; $display("FAIL lw_maddr got=%h exp=41", oMAddr); end
        total++; if (oMWrite !== 1'b0) begin bad++; $display("FAIL lw_mwrite got=%b exp=0", oMWrite); end
        total++; if (oMByteEn !== 4'b1111) begin bad++; $display("FAIL lw_byteen got=%b exp=1111", oMByteEn); end
        total++; if (oBusy !== 1'b1 || oReady !== 1'b0) begin bad++; $display("FAIL lw_busy_req got=%b%b exp=10", oBusy, oReady); end
        iMAck   = 1'b1;
        iMRData = 32'h8000_00FF;
        step();
        iMAck = 1'b0;
        exp_rdata = 32'h8000_00FF;
        total++; if (oReady !== 1'b1) begin bad++; $display("FAIL lw_ready got=%b exp=1", oReady); end
        total++; if (oRData !== exp_rdata) begin bad++; $display("FAIL lw_rdata got=%h exp=%h", oRData, exp_rdata); end
        total++; if (oMReq !== 1'b0) begin bad++; $display("FAIL lw_mreq_drop got=%b exp=0", oMReq); end
        total++; if (oErr !== 2'b00) begin bad++; $display("FAIL lw_err got=%b exp=00", oErr); end
        iMemRead = 1'b0;
        step();
        total++; if (oReady !== 1'b0 || oBusy !== 1'b0) begin bad++; $display("FAIL lw_idle got=%b%b exp=00", oReady, oBusy); end
    endtask

    task automatic test_loads();
        logic [31:0] t_addr [6] = '{32'h103, 32'h103, 32'h100, 32'h102, 32'h101, 32'h10C};
        logic [2:0]  t_f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
        logic [31:0] t_mem  [6] = '{32'h80AB_CDEF, 32'h80AB_CDEF, 32'h80AB_CDEF,
                                    32'h80AB_CDEF, 32'h0000_55AA, 32'hCAFE_F00D};
        logic [31:0] t_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_CDEF,
                                    32'h0000_80AB, 32'h0000_0055, 32'hCAFE_F00D};
        for (int i = 0; i < 6; i++) begin
            start_req(1'b1, 1'b0, t_addr[i], 32'h0, t_f3[i]);
            total++; if (oMReq !== 1'b1) begin bad++; $display("FAIL load%0d_mreq got=%b exp=1", i, oMReq); end
            iMAck   = 1'b1;
            iMRData = t_mem[i];
            step();
            iMAck    = 1'b0;
            iMemRead = 1'b0;
            exp_rdata = t_exp[i];
            total++; if (oRData !== exp_rdata || oReady !== 1'b1) begin bad++; $display("FAIL load%0d_rdata got=%h rdy=%b exp=%h rdy=1", i, oRData, oReady, exp_rdata); end
            step();
        end
    endtask

    task automatic test_stores();
        logic [31:0] t_addr [4] = '{32'h201, 32'h203, 32'h200, 32'h204};
        logic [2:0]  t_f3   [4] = '{3'b000, 3'b000, 3'b001, 3'b010};
        logic [3:0]  t_be   [4] = '{4'b0010, 4'b1000, 4'b0011, 4'b1111};
        logic [31:0] t_wd   [4] = '{32'hCDCD_CDCD, 32'hCDCD_CDCD, 32'hABCD_ABCD, 32'h1234_ABCD};
        // SH to 0x202 with three wait cycles before the acknowledge
        start_req(1'b0, 1'b1, 32'h0000_0202, 32'h1234_ABCD, 3'b001);
        for (int w = 0; w < 4; w++) begin
            if (w == 3) iMAck = 1'b1;
            total++; if (oMReq !== 1'b1 || oMWrite !== 1'b1) begin bad++; $display("FAIL sh_hold%0d got=%b%b exp=11", w, oMReq, oMWrite); end
            total++; if (oMByteEn !== 4'b1100 || oMWData !== 32'hABCD_ABCD || oMAddr !== 30'h80) begin bad++; $display("FAIL sh_lanes%0d got=%b %h %h exp=1100 abcdabcd 80", w, oMByteEn, oMWData, oMAddr); end
            step();
        end
        iMAck     = 1'b0;
        iMemWrite = 1'b0;
        total++; if (oReady !== 1'b1 || oErr !== 2'b00) begin bad++; $display("FAIL sh_done got=%b %b exp=1 00", oReady, oErr); end
        total++; if (oRData !== exp_rdata) begin bad++; $display("FAIL sh_rdata_kept got=%h exp=%h", oRData, exp_rdata); end
        step();
        for (int i = 0; i < 4; i++) begin
            start_req(1'b0, 1'b1, t_addr[i], 32'h1234_ABCD, t_f3[i]);
            total++; if (oMByteEn !== t_be[i] || oMWData !== t_wd[i]) begin bad++; $display("FAIL st%0d_lanes got=%b %h exp=%b %h", i, oMByteEn, oMWData, t_be[i], t_wd[i]); end
            iMAck = 1'b1;
            step();
            iMAck     = 1'b0;
            iMemWrite = 1'b0;
            total++; if (oReady !== 1'b1) begin bad++; $display("FAIL st%0d_ready got=%b exp=1", i, oReady); end
            step();
        end
    endtask

    task automatic test_errors();
        logic       t_rd  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       t_wr  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_a  [6] = '{32'h101, 32'h103, 32'h202, 32'h100, 32'h100, 32'h100};
        logic [2:0] t_f3  [6] = '{3'b010, 3'b101, 3'b010, 3'b010, 3'b011, 3'b110};
        logic [1:0] t_err [6] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
        for (int i = 0; i < 6; i++) begin
            start_req(t_rd[i], t_wr[i], t_a[i], 32'h5555_5555, t_f3[i]);
            total++; if (oReady !== 1'b1 || oErr !== t_err[i]) begin bad++; $display("FAIL err%0d_done got=%b %b exp=1 %b", i, oReady, oErr, t_err[i]); end
            total++; if (oMReq !== 1'b0 || oBusy !== 1'b1) begin bad++; $display("FAIL err%0d_noreq got=%b%b exp=01", i, oMReq, oBusy); end
            iMemRead  = 1'b0;
            iMemWrite = 1'b0;
            step();
            total++; if (oReady !== 1'b0 || oMReq !== 1'b0 || oErr !== t_err[i]) begin bad++; $display("FAIL err%0d_held got=%b%b %b exp=00 %b", i, oReady, oMReq, oErr, t_err[i]); end
        end
        total++; if (oRData !== exp_rdata) begin bad++; $display("FAIL err_rdata_kept got=%h exp=%h", oRData, exp_rdata); end
        start_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
        total++; if (oErr !== 2'b00 || oMReq !== 1'b1) begin bad++; $display("FAIL err_clear got=%b %b exp=00 1", oErr, oMReq); end
        iMAck   = 1'b1;
        iMRData = 32'h0BAD_F00D;
        step();
        iMAck     = 1'b0;
        iMemRead  = 1'b0;
        exp_rdata = 32'h0BAD_F00D;
        step();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int rdy_cycles = 0;
        start_req(1'b1, 1'b0, 32'h0000_0108, 32'h0, 3'b010);
        iMemRead = 1'b0;
        iMAck    = 1'b0;
        iMRData  = 32'hFFFF_0000;
        for (int i = 0; i < 10; i++) begin
            if (oMReq === 1'b1) req_cycles++;
            if (oReady === 1'b1) rdy_cycles++;
            step();
        end
        total++; if (req_cycles != 4) begin bad++; $display("FAIL to_req_cycles got=%0d exp=4", req_cycles); end
        total++; if (rdy_cycles != 1) begin bad++; $display("FAIL to_ready_pulses got=%0d exp=1", rdy_cycles); end
        total++; if (oErr !== 2'b10) begin bad++; $display("FAIL to_err got=%b exp=10", oErr); end
        total++; if (oRData !== exp_rdata) begin bad++; $display("FAIL to_rdata_kept got=%h exp=%h", oRData, exp_rdata); end
        total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b exp=0", oBusy); end
    endtask

    task automatic test_ignore();
        start_req(1'b1, 1'b0, 32'h0000_0110, 32'h0, 3'b010);
        iMemRead = 1'b0;
        step();
        iMemRead = 1'b1;
        step();
        iMAck   = 1'b1;
        iMRData = 32'h1357_2468;
        step();
        iMAck     = 1'b0;
        exp_rdata = 32'h1357_2468;
        total++; if (oReady !== 1'b1 || oRData !== exp_rdata) begin bad++; $display("FAIL ign_done got=%b %h exp=1 %h", oReady, oRData, exp_rdata); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (oBusy !== 1'b0 || oMReq !== 1'b0) begin bad++; $display("FAIL ign_noqueue%0d got=%b%b exp=00", i, oBusy, oMReq); end
        end
        iMemRead = 1'b0;
        step();
    endtask

    task automatic test_reset_midflight();
        start_req(1'b1, 1'b0, 32'h0000_0120, 32'h0, 3'b010);
        total++; if (oMReq !== 1'b1) begin bad++; $display("FAIL rmf_mreq got=%b exp=1", oMReq); end
        iRST_n = 1'b0;
        step();
        exp_rdata = RST_DATA;
        total++; if (oMReq !== 1'b0 || oBusy !== 1'b0 || oReady !== 1'b0) begin bad++; $display("FAIL rmf_abort got=%b%b%b exp=000", oMReq, oBusy, oReady); end
        total++; if (oRData !== exp_rdata) begin bad++; $display("FAIL rmf_rdata got=%h exp=%h", oRData, exp_rdata); end
        iRST_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (oBusy !== 1'b0 || oMReq !== 1'b0) begin bad++; $display("FAIL rmf_held%0d got=%b%b exp=00", i, oBusy, oMReq); end
        end
        iMemRead = 1'b0;
        step();
        iMemRead = 1'b1;
        step();
        total++; if (oMReq !== 1'b1 || oMAddr !== 30'h48) begin bad++; $display("FAIL rmf_rearm got=%b %h exp=1 48", oMReq, oMAddr); end
        iMAck   = 1'b1;
        iMRData = 32'h2468_ACE0;
        step();
        iMAck     = 1'b0;
        iMemRead  = 1'b0;
        exp_rdata = 32'h2468_ACE0;
        total++; if (oReady !== 1'b1 || oRData !== exp_rdata) begin bad++; $display("FAIL rmf_done got=%b %h exp=1 %h", oReady, oRData, exp_rdata); end
        step();
    endtask

    initial begin
        iRST_n    = 1'b0;
        iMemRead  = 1'b0;
        iMemWrite = 1'b0;
        iAddr     = 32'h0;
        iWData    = 32'h0;
        iFunct3   = 3'b000;
        iMAck     = 1'b0;
        iMRData   = 32'h0;
        exp_rdata = RST_DATA;
        test_reset();
        test_lw();
        test_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_ignore();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_access_multi.md
MEM_ACCESS_MULTI -- requirements
Module: mem_access_multi

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for iMAck before aborting.
REQ-002 SHALL have parameter RESET_VEC_DATA, default 32'h0000_0000, giving the reset value of oRData.
REQ-003 SHALL have port iCLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port iRST_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 SHALL have port iMemRead, input, 1 bit, the read request level from the multicycle control.
REQ-006 SHALL have port iMemWrite, input, 1 bit, the write request level from the multicycle control.
REQ-007 SHALL have port iAddr, input, 32 bits, the byte address already selected by IouD.
REQ-008 SHALL have port iWData, input, 32 bits, the store data (register B).
REQ-009 SHALL have port iFunct3, input, 3 bits, the size/sign code: 000=B, 001=H, 010=W, 100=BU, 101=HU.
REQ-010 SHALL have port oRData, output, 32 bits, the aligned and extended load data (MDR input).
REQ-011 SHALL have port oReady, output, 1 bit, a one-cycle completion pulse.
REQ-012 SHALL have port oBusy, output, 1 bit, which is high while an access is in flight.
REQ-013 SHALL have port oErr, output, 2 bits: 00=none, 01=misaligned, 10=timeout, 11=illegal request.
REQ-014 SHALL have port oMReq, output, 1 bit, the memory request.
REQ-015 SHALL have port oMWrite, output, 1 bit, which is 1 for write and 0 for read.
REQ-016 SHALL have port oMAddr, output, 30 bits, the word address iAddr[31:2].
REQ-017 SHALL have port oMWData, output, 32 bits, the lane-shifted store data.
REQ-018 SHALL have port oMByteEn, output, 4 bits, the byte lane enables.
REQ-019 SHALL have port iMAck, input, 1 bit, the memory acknowledge.
REQ-020 SHALL have port iMRData, input, 32 bits, the memory read word, valid when iMAck=1.

Function
REQ-021 SHALL implement an FSM with states IDLE, REQ, DONE.
REQ-022 SHALL accept a request only in IDLE, and only on the rising edge of (iMemRead|iMemWrite), detected against a registered copy of that level; a held level SHALL NOT re-trigger.
REQ-023 On acceptance, SHALL register iAddr, iWData, iFunct3 and the direction, and go to REQ the next cycle.
REQ-024 SHALL treat iMemRead=iMemWrite=1 at an accepted edge as illegal: go to DONE with oErr=11 and issue no memory request.
REQ-025 SHALL treat an undefined iFunct3 (011, 110, 111) at an accepted edge as illegal: go to DONE with oErr=11 and issue no memory request.
REQ-026 SHALL detect misalignment (H/HU with addr[0]=1; W with addr[1:0]!=00), then go to DONE with oErr=01 and issue no memory request.
REQ-027 In REQ, SHALL hold oMReq=1 and keep oMAddr, oMWrite, oMByteEn and oMWData stable until iMAck=1.
REQ-028 SHALL, when iMAck=1 is sampled in REQ, capture load data and go to DONE, with oMReq deasserting the following cycle.
REQ-029 SHALL, for stores, drive oMByteEn as: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
REQ-030 SHALL, for stores, drive oMWData as iWData replicated into the lanes selected by oMByteEn.
REQ-031 SHALL drive oMByteEn=1111 for reads.
REQ-032 SHALL, for loads, shift iMRData right by 8*addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU) to 32 bits, or pass the word unchanged (W).
REQ-033 SHALL count REQ cycles with a counter reset on entry to REQ; reaching TIMEOUT without iMAck SHALL force DONE with oErr=10 and leave oRData unchanged.
REQ-034 In DONE, SHALL assert oReady=1 for exactly one cycle and return to IDLE.
REQ-035 SHALL hold oErr from DONE until the next accepted request, which clears it.
REQ-036 SHALL hold oRData until the next successful load completes.
REQ-037 SHALL drive oBusy=1 in REQ and DONE, and 0 in IDLE.
REQ-038 SHALL give a zero-wait read (iMAck in the first REQ cycle) a latency of 2 cycles from the edge-accept cycle to oReady.
REQ-039 SHALL ignore request edges that occur while not in IDLE; they SHALL NOT be queued.

Reset
REQ-040 While iRST_n=0 at a clock edge, SHALL set state IDLE, oMReq=0, oMWrite=0, oMByteEn=0000, oMAddr=0, oMWData=0, oRData=RESET_VEC_DATA, oReady=0, oBusy=0, oErr=00, counter=0, and the edge register=0.
REQ-041 SHALL abandon an access in flight when reset is applied, with oMReq low the cycle after the reset edge.
REQ-042 After reset release, a request level already high SHALL NOT be accepted until it has been low for one cycle.

Verification
REQ-043 LW rising edge, iAddr=0x104, memory acks immediately with 0x8000_00FF -> oMAddr=0x41, oRData=0x8000_00FF, oReady 2 cycles after the edge.
REQ-044 LB addr=0x103, iMRData=0x80AB_CDEF -> oRData=0xFFFF_FF80; LBU at the same address -> oRData=0x0000_0080.
REQ-045 SH iWData=0x1234_ABCD, addr=0x202 -> oMByteEn=1100, oMWData=0xABCD_ABCD, oMWrite=1 held across 3 wait cycles until iMAck.
REQ-046 LW addr=0x101 -> oErr=01, oMReq never asserted, oReady pulses once; iMemRead=iMemWrite=1 -> oErr=11, no memory request.
REQ-047 TIMEOUT=4 with iMAck held low -> oErr=10 after 4 REQ cycles, oRData unchanged, oReady single pulse.
REQ-048 iRST_n low during REQ -> oMReq=0 and state IDLE the next cycle; iMemRead held high across release -> no new access until it toggles low then high.
